// File: rtl/rca_config.sv
// Shared RCA configuration: grid geometry and the request bundle
// that the PR queue push path consumes.
package rca_config;

  localparam int NUM_GRID_SLOTS = 4;
  localparam int OU_ID_W        = 4;
  localparam int GRID_SLOT_W    = 2;

  typedef struct packed {
    logic [OU_ID_W-1:0]     ou_id;
    logic [GRID_SLOT_W-1:0] grid_slot;
  } pr_queue_inputs_t;

endpackage

// File: rtl/pr_slot_scoreboard.sv
// Per-slot outstanding-reconfiguration bits.
// Ports: set_i/set_idx_i mark busy, clr_i/clr_idx_i release, busy_o vector.
module pr_slot_scoreboard #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  output logic [N-1:0]     busy_o
);

  logic [N-1:0] busy_q, busy_d;

  // set is applied last so it wins on a same-index collision
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/pr_request_filter.sv
// Filters profiler candidates before the PR queue: drops busy-slot,
// out-of-range and hold-off candidates, forwards the rest over valid/ready.
// Ports: cand_* in, req_* out, done_* release, slot_busy/holdoff_active/drop_count status.
module pr_request_filter
  import rca_config::*;
#(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [OU_ID_W-1:0]        cand_ou_id,
  input  logic [GRID_SLOT_W-1:0]    cand_grid_slot,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [OU_ID_W-1:0]        req_ou_id,
  output logic [GRID_SLOT_W-1:0]    req_grid_slot,
  input  logic                      done_valid,
  input  logic [GRID_SLOT_W-1:0]    done_grid_slot,
  output logic [NUM_GRID_SLOTS-1:0] slot_busy,
  output logic                      holdoff_active,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ?
                      $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [GRID_SLOT_W:0] NSLOTS =
    NUM_GRID_SLOTS[GRID_SLOT_W:0];

  typedef enum logic {IDLE, HOLDOFF} hold_state_e;

  hold_state_e             state_q, state_d;
  logic [HW-1:0]           hcnt_q, hcnt_d;
  logic                    req_valid_q, req_valid_d;
  pr_queue_inputs_t        req_q, req_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic [NUM_GRID_SLOTS-1:0] busy;

  logic cand_in_range;
  logic done_in_range;
  logic accept;
  logic drop;
  logic fwd;

  assign cand_ready    = !req_valid_q || req_ready;
  assign cand_in_range = {1'b0, cand_grid_slot} < NSLOTS;
  assign done_in_range = {1'b0, done_grid_slot} < NSLOTS;
  assign accept        = cand_valid && cand_ready;

  // decision uses registered busy/state only
  assign drop = accept && (!cand_in_range ||
                           state_q == HOLDOFF ||
                           busy[cand_grid_slot]);
  assign fwd  = accept && !drop;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (fwd && HOLDOFF_CYCLES > 0) begin
          state_d = HOLDOFF;
          hcnt_d  = HW'(HOLDOFF_CYCLES);
        end
      end
      HOLDOFF: begin
        if (hcnt_q == HW'(1)) begin
          state_d = IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  // a new forward may reload the register in the same cycle it drains
  always_comb begin
    req_valid_d = req_valid_q;
    req_d       = req_q;
    if (fwd) begin
      req_valid_d     = 1'b1;
      req_d.ou_id     = cand_ou_id;
      req_d.grid_slot = cand_grid_slot;
    end else if (req_ready) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      req_valid_q <= 1'b0;
      req_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      drop_q      <= drop_d;
    end
  end

  pr_slot_scoreboard #(
    .N     (NUM_GRID_SLOTS),
    .IDX_W (GRID_SLOT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_i     (fwd),
    .set_idx_i (cand_grid_slot),
    .clr_i     (done_valid && done_in_range),
    .clr_idx_i (done_grid_slot),
    .busy_o    (busy)
  );

  assign req_valid      = req_valid_q;
  assign req_ou_id      = req_q.ou_id;
  assign req_grid_slot  = req_q.grid_slot;
  assign slot_busy      = busy;
  assign holdoff_active = (state_q == HOLDOFF);
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_pr_request_filter.sv
// Bench for pr_request_filter: cycle model plus directed scenarios.
module tb_pr_request_filter;

  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cand_valid;
  logic       cand_ready;
  logic [3:0] cand_ou_id;
  logic [1:0] cand_grid_slot;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_ou_id;
  logic [1:0] req_grid_slot;
  logic       done_valid;
  logic [1:0] done_grid_slot;
  logic [3:0] slot_busy;
  logic       holdoff_active;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pr_request_filter #(
    .HOLDOFF_CYCLES (HOLD),
    .DROP_CNT_W     (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cand_valid     (cand_valid),
    .cand_ready     (cand_ready),
    .cand_ou_id     (cand_ou_id),
    .cand_grid_slot (cand_grid_slot),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ou_id      (req_ou_id),
    .req_grid_slot  (req_grid_slot),
    .done_valid     (done_valid),
    .done_grid_slot (done_grid_slot),
    .slot_busy      (slot_busy),
    .holdoff_active (holdoff_active),
    .drop_count     (drop_count)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: request register, busy set, hold-off window end, drops
  bit     mv;
  int     mou;
  int     mslot;
  bit     mbusy [4];
  int     mdrops;
  longint cyc;
  longint hold_end;
  bit     m_rdy, m_acc, m_fw;
  logic [3:0] eb;

  always @(negedge clk) begin
    if (rst) begin
      mv = 0; mou = 0; mslot = 0; mdrops = 0;
      foreach (mbusy[i]) mbusy[i] = 0;
      cyc = 0; hold_end = -1;
    end
    for (int i = 0; i < 4; i++) eb[i] = mbusy[i];
    check("m_req_valid", 32'(req_valid), 32'(mv));
    check("m_req_ou", 32'(req_ou_id), 32'(mou));
    check("m_req_slot", 32'(req_grid_slot), 32'(mslot));
    check("m_busy", 32'(slot_busy), 32'(eb));
    check("m_holdoff", 32'(holdoff_active), 32'(cyc <= hold_end));
    check("m_drops", 32'(drop_count), 32'(mdrops));
    check("m_cand_ready", 32'(cand_ready), 32'(!mv || req_ready));
    if (!rst) begin
      m_rdy = !mv || req_ready;
      m_acc = cand_valid && m_rdy;
      m_fw  = 0;
      if (m_acc) begin
        if (mbusy[cand_grid_slot] || cyc <= hold_end ||
            int'(cand_grid_slot) >= 4) begin
          if (mdrops < 65535) mdrops++;
        end else begin
          m_fw = 1;
        end
      end
      if (m_fw) begin
        mv = 1; mou = int'(cand_ou_id); mslot = int'(cand_grid_slot);
        hold_end = cyc + HOLD;
      end else if (req_ready) begin
        mv = 0;
      end
      if (done_valid && int'(done_grid_slot) < 4) mbusy[done_grid_slot] = 0;
      if (m_fw) mbusy[cand_grid_slot] = 1;
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cand(input logic [3:0] ou, input logic [1:0] sl);
    cand_valid = 1'b1; cand_ou_id = ou; cand_grid_slot = sl;
  endtask

  initial begin
    rst = 1'b1; cand_valid = 1'b0; cand_ou_id = '0; cand_grid_slot = '0;
    req_ready = 1'b0; done_valid = 1'b0; done_grid_slot = '0;
    step(2);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_busy", 32'(slot_busy), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_holdoff", 32'(holdoff_active), 32'd0);
    rst = 1'b0;

    // first forward
    req_ready = 1'b1;
    cand(4'd3, 2'd1);
    step(1);
    check("t1_valid", 32'(req_valid), 32'd1);
    check("t1_ou", 32'(req_ou_id), 32'd3);
    check("t1_slot", 32'(req_grid_slot), 32'd1);
    check("t1_busy", 32'(slot_busy), 32'b0010);
    check("t1_holdoff", 32'(holdoff_active), 32'd1);

    // hold-off window: 16 drops then a forward
    cand(4'd2, 2'd2);
    step(16);
    check("t2_drops16", 32'(drop_count), 32'd16);
    check("t2_drained", 32'(req_valid), 32'd0);
    step(1);
    check("t2_fwd_valid", 32'(req_valid), 32'd1);
    check("t2_fwd_slot", 32'(req_grid_slot), 32'd2);
    check("t2_drops_keep", 32'(drop_count), 32'd16);
    check("t2_busy", 32'(slot_busy), 32'b0110);
    cand_valid = 1'b0;
    step(20);

    // busy drop, release, re-forward
    cand(4'd5, 2'd1);
    step(1);
    check("t3_drop", 32'(drop_count), 32'd17);
    cand_valid = 1'b0;
    done_valid = 1'b1; done_grid_slot = 2'd1;
    step(1);
    done_valid = 1'b0;
    check("t3_release", 32'(slot_busy), 32'b0100);
    cand(4'd5, 2'd1);
    step(1);
    check("t3_fwd_ou", 32'(req_ou_id), 32'd5);
    check("t3_busy", 32'(slot_busy), 32'b0110);
    cand_valid = 1'b0;
    step(20);

    // back-pressure holds the request
    done_valid = 1'b1; done_grid_slot = 2'd2;
    step(1);
    done_valid = 1'b0;
    check("t4_release", 32'(slot_busy), 32'b0010);
    req_ready = 1'b0;
    cand(4'd9, 2'd3);
    step(1);
    check("t4_valid", 32'(req_valid), 32'd1);
    cand(4'd10, 2'd0);
    for (int i = 0; i < 10; i++) begin
      check("t4_cand_ready", 32'(cand_ready), 32'd0);
      check("t4_ou_stable", 32'(req_ou_id), 32'd9);
      check("t4_slot_stable", 32'(req_grid_slot), 32'd3);
      step(1);
    end
    check("t4_no_drop", 32'(drop_count), 32'd17);
    cand_valid = 1'b0;
    req_ready = 1'b1;
    #1;
    check("t4_ready_back", 32'(cand_ready), 32'd1);
    step(1);
    check("t4_pushed", 32'(req_valid), 32'd0);
    step(20);

    // same-cycle done + candidate on the same slot
    cand(4'd1, 2'd0);
    step(1);
    cand_valid = 1'b0;
    step(20);
    check("t5_busy0", 32'(slot_busy), 32'b1011);
    done_valid = 1'b1; done_grid_slot = 2'd0;
    cand(4'd7, 2'd0);
    step(1);
    check("t5_drop", 32'(drop_count), 32'd18);
    check("t5_cleared", 32'(slot_busy), 32'b1010);
    // same-cycle done + forward on a different slot
    done_grid_slot = 2'd1;
    cand(4'd4, 2'd2);
    step(1);
    done_valid = 1'b0; cand_valid = 1'b0;
    check("t5_both", 32'(slot_busy), 32'b1100);
    check("t5_fwd_ou", 32'(req_ou_id), 32'd4);
    step(20);

    // saturate the drop counter
    cand(4'd8, 2'd3);
    step(65540);
    cand_valid = 1'b0;
    check("t6_sat", 32'(drop_count), 32'hFFFF);
    step(1);

    // async reset with a request held
    done_valid = 1'b1; done_grid_slot = 2'd2;
    step(1);
    done_valid = 1'b0;
    req_ready = 1'b0;
    cand(4'd6, 2'd2);
    step(1);
    cand_valid = 1'b0;
    check("t6_held", 32'(req_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(req_valid), 32'd0);
    check("t6_rst_ou", 32'(req_ou_id), 32'd0);
    check("t6_rst_slot", 32'(req_grid_slot), 32'd0);
    check("t6_rst_busy", 32'(slot_busy), 32'd0);
    check("t6_rst_hold", 32'(holdoff_active), 32'd0);
    check("t6_rst_drops", 32'(drop_count), 32'd0);
    check("t6_rst_ready", 32'(cand_ready), 32'd1);
    step(1);
    rst = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
